// File: rtl/cache_status_table_pkg.sv
// Shared definitions for the cache status table: default geometry,
// controller state encodings and the way-width helper.
package cache_status_table_pkg;

    localparam int CACHE_INDEX_W = 8;
    localparam int CACHE_WAYS    = 2;

    typedef enum logic [2:0] {
        CST_INIT = 3'd0,
        CST_IDLE = 3'd1,
        CST_SCAN = 3'd2,
        CST_OUT  = 3'd3,
        CST_DONE = 3'd4
    } cst_state_e;

    // Way number width; a single-way table still carries a 1-bit way field.
    function automatic int way_w(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/cache_status_table_if.sv
// Lookup/update port from the cache control FSM and the flush port towards
// the write-back engine, bundled as one interface.
interface cache_status_table_if
    import cache_status_table_pkg::*;
#(
    parameter int INDEX_W  = CACHE_INDEX_W,
    parameter int NUM_WAYS = CACHE_WAYS
) ();

    localparam int WAY_W = way_w(NUM_WAYS);

    logic [INDEX_W-1:0]  index_i;
    logic                wr_en_i;
    logic [WAY_W-1:0]    wr_way_i;
    logic                wr_valid_i;
    logic                wr_dirty_i;
    logic [NUM_WAYS-1:0] rd_valid_o;
    logic [NUM_WAYS-1:0] rd_dirty_o;
    logic                init_busy_o;
    logic                flush_req_i;
    logic                flush_busy_o;
    logic                flush_vld_o;
    logic                flush_rdy_i;
    logic [INDEX_W-1:0]  flush_idx_o;
    logic [WAY_W-1:0]    flush_way_o;
    logic                flush_done_o;

    modport slave (
        input  index_i, wr_en_i, wr_way_i, wr_valid_i, wr_dirty_i,
        input  flush_req_i, flush_rdy_i,
        output rd_valid_o, rd_dirty_o, init_busy_o,
        output flush_busy_o, flush_vld_o, flush_idx_o, flush_way_o, flush_done_o
    );

    modport master (
        output index_i, wr_en_i, wr_way_i, wr_valid_i, wr_dirty_i,
        output flush_req_i, flush_rdy_i,
        input  rd_valid_o, rd_dirty_o, init_busy_o,
        input  flush_busy_o, flush_vld_o, flush_idx_o, flush_way_o, flush_done_o
    );

endinterface

// File: rtl/cache_status_table_prio_enc.sv
// Lowest-set-bit encoder: picks the lowest-numbered dirty way of a set.
module prio_enc #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_status_table.sv
// Per-set, per-way valid/dirty table with a post-reset clearing sweep,
// write-first lookup forwarding and a flush scanner for dirty lines.
//
// state | meaning
// INIT  | clearing set ptr each cycle after reset
// IDLE  | lookup/update port active
// SCAN  | testing set ptr for valid & dirty ways
// OUT   | presenting one dirty line to the write-back unit
// DONE  | one-cycle completion pulse
module cache_status_table
    import cache_status_table_pkg::*;
#(
    parameter int INDEX_W  = CACHE_INDEX_W,
    parameter int NUM_WAYS = CACHE_WAYS
) (
    input logic                   clk,
    input logic                   rst,
    cache_status_table_if.slave   bus
);

    localparam int WAY_W = way_w(NUM_WAYS);
    localparam int DEPTH = 2 ** INDEX_W;

    logic [NUM_WAYS-1:0] valid_q [DEPTH];
    logic [NUM_WAYS-1:0] dirty_q [DEPTH];

    cst_state_e          state_q, state_d;
    logic [INDEX_W-1:0]  ptr_q, ptr_d;
    logic [INDEX_W-1:0]  fidx_q, fidx_d;
    logic [WAY_W-1:0]    fway_q, fway_d;
    logic [NUM_WAYS-1:0] rdv_q, rdd_q;
    logic [NUM_WAYS-1:0] lk_v, lk_d;
    logic [NUM_WAYS-1:0] scan_mask;
    logic [WAY_W-1:0]    enc_way;
    logic                enc_found;
    logic                clr_set;
    logic                clr_dirty;
    logic                upd;
    logic                last_set;

    assign scan_mask = valid_q[ptr_q] & dirty_q[ptr_q];
    assign last_set  = &ptr_q;
    assign upd       = (state_q == CST_IDLE) && bus.wr_en_i;

    prio_enc #(
        .N (NUM_WAYS),
        .W (WAY_W)
    ) u_prio_enc (
        .req   (scan_mask),
        .idx   (enc_way),
        .found (enc_found)
    );

    // Next-state logic; the terminal set is detected explicitly so ptr never wraps.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        fidx_d    = fidx_q;
        fway_d    = fway_q;
        clr_set   = 1'b0;
        clr_dirty = 1'b0;
        case (state_q)
            CST_INIT: begin
                clr_set = 1'b1;
                if (last_set) begin
                    state_d = CST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + INDEX_W'(1);
                end
            end
            CST_IDLE: begin
                if (bus.flush_req_i) begin
                    state_d = CST_SCAN;
                    ptr_d   = '0;
                end
            end
            CST_SCAN: begin
                if (enc_found) begin
                    fidx_d  = ptr_q;
                    fway_d  = enc_way;
                    state_d = CST_OUT;
                end else if (last_set) begin
                    state_d = CST_DONE;
                end else begin
                    ptr_d = ptr_q + INDEX_W'(1);
                end
            end
            CST_OUT: begin
                // Stay on the same set so its remaining dirty ways are found next.
                if (bus.flush_rdy_i) begin
                    clr_dirty = 1'b1;
                    state_d   = CST_SCAN;
                end
            end
            CST_DONE: begin
                state_d = CST_IDLE;
            end
            default: begin
                state_d = CST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // Controller registers; reset restarts the init sweep from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CST_INIT;
            ptr_q   <= '0;
            fidx_q  <= '0;
            fway_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fidx_q  <= fidx_d;
            fway_q  <= fway_d;
        end
    end

    // Status array updates: sweep clear, controller write, flush acknowledge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_set) begin
                valid_q[ptr_q] <= '0;
                dirty_q[ptr_q] <= '0;
            end
            if (upd) begin
                valid_q[bus.index_i][bus.wr_way_i] <= bus.wr_valid_i;
                dirty_q[bus.index_i][bus.wr_way_i] <= bus.wr_dirty_i;
            end
            if (clr_dirty) begin
                dirty_q[fidx_q][fway_q] <= 1'b0;
            end
        end
    end

    // Lookup with write-first forwarding of the way being written.
    always_comb begin
        lk_v = valid_q[bus.index_i];
        lk_d = dirty_q[bus.index_i];
        if (bus.wr_en_i) begin
            lk_v[bus.wr_way_i] = bus.wr_valid_i;
            lk_d[bus.wr_way_i] = bus.wr_dirty_i;
        end
    end

    // Registered read port; blanked whenever the controller is not staying in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdv_q <= '0;
            rdd_q <= '0;
        end else if (state_q == CST_IDLE && state_d == CST_IDLE) begin
            rdv_q <= lk_v;
            rdd_q <= lk_d;
        end else begin
            rdv_q <= '0;
            rdd_q <= '0;
        end
    end

    assign bus.rd_valid_o   = rdv_q;
    assign bus.rd_dirty_o   = rdd_q;
    assign bus.init_busy_o  = (state_q == CST_INIT);
    assign bus.flush_busy_o = (state_q == CST_SCAN) || (state_q == CST_OUT);
    assign bus.flush_vld_o  = (state_q == CST_OUT);
    assign bus.flush_idx_o  = fidx_q;
    assign bus.flush_way_o  = fway_q;
    assign bus.flush_done_o = (state_q == CST_DONE);

endmodule

// File: tb/tb_cache_status_table.sv
// Bench for cache_status_table with a 16-set, 2-way table and a plain
// array model of the valid/dirty contents.
module tb_cache_status_table;
    import cache_status_table_pkg::*;

    localparam int IW    = 4;
    localparam int NW    = 2;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;

    cache_status_table_if #(.INDEX_W(IW), .NUM_WAYS(NW)) bus ();

    cache_status_table #(.INDEX_W(IW), .NUM_WAYS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit m_valid [DEPTH][NW];
    bit m_dirty [DEPTH][NW];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mv(input int s);
        logic [31:0] r = '0;
        for (int w = 0; w < NW; w++) r[w] = m_valid[s][w];
        return r;
    endfunction

    function automatic logic [31:0] md(input int s);
        logic [31:0] r = '0;
        for (int w = 0; w < NW; w++) r[w] = m_dirty[s][w];
        return r;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < DEPTH; s++)
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
    endtask

    task automatic wait_init(input string tag);
        int cnt   = 1;
        int dones = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (bus.flush_done_o) dones++;
            if (bus.init_busy_o) cnt++;
            else break;
        end
        chk(tag, 32'(cnt), 32'(DEPTH));
        chk({tag, "_no_done"}, 32'(dones), 32'd0);
    endtask

    task automatic read_all(input string tag);
        bus.wr_en_i = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            bus.index_i = IW'(s);
            tick();
            chk({tag, "_valid"}, 32'(bus.rd_valid_o), mv(s));
            chk({tag, "_dirty"}, 32'(bus.rd_dirty_o), md(s));
        end
    endtask

    task automatic wr(input int s, input int w, input bit v, input bit d);
        bus.index_i    = IW'(s);
        bus.wr_en_i    = 1'b1;
        bus.wr_way_i   = 1'(w);
        bus.wr_valid_i = v;
        bus.wr_dirty_i = d;
        tick();
        m_valid[s][w] = v;
        m_dirty[s][w] = d;
        bus.wr_en_i = 1'b0;
        chk("wr_fwd_valid", 32'(bus.rd_valid_o), mv(s));
        chk("wr_fwd_dirty", 32'(bus.rd_dirty_o), md(s));
    endtask

    // Expected beats: every (set, way) in ascending order that is valid and dirty.
    task automatic run_flush(input int stall, input bit poke2, input int exp_beats);
        int q_idx[$];
        int q_way[$];
        int beats   = 0;
        int stalled = 0;
        int dones   = 0;
        for (int s = 0; s < DEPTH; s++)
            for (int w = 0; w < NW; w++)
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    q_idx.push_back(s);
                    q_way.push_back(w);
                end
        if (exp_beats >= 0) chk("flush_plan_size", 32'(q_idx.size()), 32'(exp_beats));
        bus.flush_req_i = 1'b1;
        bus.flush_rdy_i = 1'b1;
        tick();
        bus.flush_req_i = 1'b0;
        chk("flush_busy_start", 32'(bus.flush_busy_o), 32'd1);
        for (int c = 0; c < 300; c++) begin
            if (poke2) begin
                bus.index_i    = IW'(2);
                bus.wr_en_i    = 1'b1;
                bus.wr_way_i   = 1'b0;
                bus.wr_valid_i = 1'b0;
                bus.wr_dirty_i = 1'b1;
            end
            if (bus.flush_done_o) begin
                dones++;
                break;
            end
            chk("flush_rd_blank", 32'({bus.rd_valid_o, bus.rd_dirty_o}), 32'd0);
            if (bus.flush_vld_o) begin
                if (beats < q_idx.size()) begin
                    chk("flush_idx", 32'(bus.flush_idx_o), 32'(q_idx[beats]));
                    chk("flush_way", 32'(bus.flush_way_o), 32'(q_way[beats]));
                end else begin
                    chk("flush_extra_beat", 32'd1, 32'(beats - q_idx.size()));
                end
                if (beats == 0 && stalled < stall) begin
                    bus.flush_rdy_i = 1'b0;
                    stalled++;
                end else begin
                    bus.flush_rdy_i = 1'b1;
                    if (beats < q_idx.size()) m_dirty[q_idx[beats]][q_way[beats]] = 1'b0;
                    beats++;
                end
            end else begin
                bus.flush_rdy_i = 1'b1;
            end
            tick();
        end
        bus.wr_en_i = 1'b0;
        chk("flush_done_seen", 32'(dones), 32'd1);
        chk("flush_beats", 32'(beats), 32'(q_idx.size()));
        chk("flush_stall_cycles", 32'(stalled), 32'(stall));
        chk("flush_busy_at_done", 32'(bus.flush_busy_o), 32'd0);
        tick();
        chk("flush_done_one_cycle", 32'(bus.flush_done_o), 32'd0);
    endtask

    initial begin
        int seen;
        rst            = 1'b1;
        bus.index_i    = '0;
        bus.wr_en_i    = 1'b0;
        bus.wr_way_i   = '0;
        bus.wr_valid_i = 1'b0;
        bus.wr_dirty_i = 1'b0;
        bus.flush_req_i = 1'b0;
        bus.flush_rdy_i = 1'b0;
        clear_model();

        tick();
        tick();
        chk("rst_init_busy", 32'(bus.init_busy_o), 32'd1);
        chk("rst_flush_vld", 32'(bus.flush_vld_o), 32'd0);
        chk("rst_flush_busy", 32'(bus.flush_busy_o), 32'd0);
        chk("rst_flush_done", 32'(bus.flush_done_o), 32'd0);
        chk("rst_rd", 32'({bus.rd_valid_o, bus.rd_dirty_o}), 32'd0);
        chk("rst_flush_pos", 32'({bus.flush_idx_o, bus.flush_way_o}), 32'd0);
        rst = 1'b0;
        wait_init("init_len");
        read_all("after_init");

        // Forwarding on set 5 way 1, then a plain lookup of the same set.
        wr(5, 1, 1'b1, 1'b1);
        chk("fwd_valid_10", 32'(bus.rd_valid_o), 32'b10);
        chk("fwd_dirty_10", 32'(bus.rd_dirty_o), 32'b10);
        bus.index_i = IW'(5);
        tick();
        chk("lookup5_valid", 32'(bus.rd_valid_o), 32'b10);
        chk("lookup5_dirty", 32'(bus.rd_dirty_o), 32'b10);

        // Random lookups and writes against the model.
        for (int i = 0; i < 40; i++) begin
            int s = int'($urandom_range(0, DEPTH - 1));
            int w = int'($urandom_range(0, NW - 1));
            bit we = 1'($urandom_range(0, 1));
            bit v  = 1'($urandom_range(0, 1));
            bit d  = 1'($urandom_range(0, 1));
            bus.index_i    = IW'(s);
            bus.wr_en_i    = we;
            bus.wr_way_i   = 1'(w);
            bus.wr_valid_i = v;
            bus.wr_dirty_i = d;
            tick();
            if (we) begin
                m_valid[s][w] = v;
                m_dirty[s][w] = d;
            end
            chk("rand_valid", 32'(bus.rd_valid_o), mv(s));
            chk("rand_dirty", 32'(bus.rd_dirty_o), md(s));
        end
        bus.wr_en_i = 1'b0;

        run_flush(0, 1'b0, -1);
        read_all("after_rand_flush");

        // Three dirty lines with ready tied high.
        wr(3, 0, 1'b1, 1'b1);
        wr(3, 1, 1'b1, 1'b1);
        wr(9, 1, 1'b1, 1'b1);
        run_flush(0, 1'b0, 3);
        read_all("after_flush3");

        // Back-pressure on the first beat and writes attempted during the scan.
        wr(2, 0, 1'b1, 1'b0);
        wr(6, 1, 1'b1, 1'b1);
        wr(11, 0, 1'b1, 1'b1);
        run_flush(4, 1'b1, 2);
        read_all("after_stall_flush");

        // Reset while a line is being presented.
        wr(7, 0, 1'b1, 1'b1);
        bus.flush_rdy_i = 1'b0;
        bus.flush_req_i = 1'b1;
        tick();
        bus.flush_req_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.flush_vld_o) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk("abort_reached_out", 32'(seen), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_vld", 32'(bus.flush_vld_o), 32'd0);
        chk("abort_busy", 32'(bus.flush_busy_o), 32'd0);
        chk("abort_done", 32'(bus.flush_done_o), 32'd0);
        chk("abort_init_busy", 32'(bus.init_busy_o), 32'd1);
        rst = 1'b0;
        bus.flush_rdy_i = 1'b1;
        wait_init("abort_init_len");
        clear_model();
        read_all("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
